// File: rtl/shift_right_seq.sv
// Iterative right shifter for srl/sra/srlv/srav: one bit per clock under a
// start/busy/done handshake, so the ALU can share one small shifter.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      work   <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= data_in;
            cnt   <= shamt;
            mode  <= arith;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            // Fill comes from the current MSB, which for sra is still the sign bit.
            work <= {mode & work[WIDTH-1], work[WIDTH-1:1]};
            cnt  <= cnt - 1'b1;
          end else begin
            result <= work;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
